scrambler_gen3_par: RTL and testbench

SCRAMBLER_GEN3_PAR -- requirements
Module: scrambler_gen3_par

---
 rtl/scrambler_gen3_par.sv | 63 ++++++
 tb/tb_scrambler_gen3_par.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/scrambler_gen3_par.sv
// scrambler_gen3_par: PCIe Gen3 per-lane parallel scrambler, BYTES bytes per beat, one-deep output register
module scrambler_gen3_par #(
   parameter int BYTES   = 4,
   parameter int LANE_ID = 0
) (
   input  logic               clk_1G,
   input  logic               rst_1G,
   input  logic               en_scram,
   input  logic               seed_load,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [8*BYTES-1:0] in_data,
   input  logic [BYTES-1:0]   in_noscr,
   input  logic [BYTES-1:0]   in_skip,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [8*BYTES-1:0] out_data
);
   localparam logic [22:0] seed =
      LANE_ID == 1 ? 23'h0607BB :
      LANE_ID == 2 ? 23'h1EC760 :
      LANE_ID == 3 ? 23'h18C0DB :
      LANE_ID == 4 ? 23'h010F12 :
      LANE_ID == 5 ? 23'h19CFC9 :
      LANE_ID == 6 ? 23'h0277CE :
      LANE_ID == 7 ? 23'h1BB807 : 23'h1DBFBC;
   logic [22:0]        lr, lr_n;
   logic [8*BYTES-1:0] data_n;
   logic               accept;
   function automatic logic [22:0] lfsr_step(input logic [22:0] r);
      logic o;
      o = r[22];
      return {r[21], r[20] ^ o, r[19:16], r[15] ^ o, r[14:8], r[7] ^ o, r[6:5], r[4] ^ o, r[3:2], r[1] ^ o, r[0], o};
   endfunction
   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;
   // unroll the bit-serial scrambler across the whole beat; skipped bytes leave the LFSR untouched
   always_comb begin
      lr_n   = lr;
      data_n = in_data;
      for (int k = 0; k < BYTES; k++)
         for (int i = 0; i < 8; i++)
            if (!in_skip[k]) begin
               data_n[8*k+i] = data_n[8*k+i] ^ (en_scram & ~in_noscr[k] & lr_n[22]);
               lr_n          = lfsr_step(lr_n);
            end
   end
   // LFSR state and output register; the LFSR moves only on accepted beats or seed reloads
   always_ff @(posedge clk_1G) begin
      if (rst_1G) begin
         lr        <= seed;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (accept) begin
         lr        <= seed_load ? seed : lr_n;
         out_valid <= 1'b1;
         out_data  <= data_n;
      end else begin
         lr        <= seed_load ? seed : lr;
         out_valid <= out_valid && !out_ready;
      end
   end
endmodule

// File: tb/tb_scrambler_gen3_par.sv
// tb_scrambler_gen3_par: directed and scoreboarded checks of the Gen3 scrambler at BYTES=1 and BYTES=4
module tb_scrambler_gen3_par;
   logic        clk_1G = 1'b0;
   logic        rst_1G;
   logic        en1, sl1, iv1, ir1, ins1, isk1, ov1, or1;
   logic [7:0]  id1, od1;
   logic        en4, sl4, iv4, ir4, ov4, or4;
   logic [31:0] id4, od4;
   logic [3:0]  ins4, isk4;
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [22:0] mlr;
   logic [7:0]  b2;
   logic [7:0]  q8;
   logic [31:0] exp_q[$];
   always #5 clk_1G = ~clk_1G;

   scrambler_gen3_par #(.BYTES(1), .LANE_ID(0)) u1 (
      .clk_1G(clk_1G), .rst_1G(rst_1G), .en_scram(en1), .seed_load(sl1),
      .in_valid(iv1), .in_ready(ir1), .in_data(id1), .in_noscr(ins1), .in_skip(isk1),
      .out_valid(ov1), .out_ready(or1), .out_data(od1));

   scrambler_gen3_par #(.BYTES(4), .LANE_ID(5)) u4 (
      .clk_1G(clk_1G), .rst_1G(rst_1G), .en_scram(en4), .seed_load(sl4),
      .in_valid(iv4), .in_ready(ir4), .in_data(id4), .in_noscr(ins4), .in_skip(isk4),
      .out_valid(ov4), .out_ready(or4), .out_data(od4));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Galois-style bit-serial reference: shift left, fold the feedback tap mask in
   task automatic ref_byte(input logic [7:0] d, input logic sk, input logic ns, input logic en,
                           input logic [22:0] lr_i, output logic [22:0] lr_o, output logic [7:0] q);
      logic o;
      lr_o = lr_i;
      q    = d;
      if (!sk)
         for (int i = 0; i < 8; i++) begin
            o = lr_o[22];
            if (en && !ns) q[i] = q[i] ^ o;
            lr_o = {lr_o[21:0], o} ^ (o ? 23'h210124 : 23'h0);
         end
   endtask

   task automatic tick;
      @(posedge clk_1G);
      #1;
   endtask

   task automatic do_reset;
      rst_1G = 1'b1;
      tick();
      tick();
      rst_1G = 1'b0;
   endtask

   // one beat into the BYTES=1 instance with out_ready high; checks the registered result
   task automatic beat1(input string tag, input logic [7:0] d, input logic sk, input logic ns,
                        input logic en, input logic sl, input logic [7:0] expv);
      iv1 = 1'b1; id1 = d; isk1 = sk; ins1 = ns; en1 = en; sl1 = sl;
      tick();
      iv1 = 1'b0; sl1 = 1'b0; isk1 = 1'b0; ins1 = 1'b0; en1 = 1'b1;
      chk({tag, "_valid"}, {31'd0, ov1}, 32'd1);
      chk(tag, {24'd0, od1}, {24'd0, expv});
   endtask

   initial begin
      logic [31:0] d4, e4;
      logic [3:0]  sk4, ns4;
      logic        e;
      int          sent, cyc;
      rst_1G = 1'b1;
      en1 = 1'b1; sl1 = 1'b0; iv1 = 1'b1; id1 = 8'h55; ins1 = 1'b0; isk1 = 1'b0; or1 = 1'b1;
      en4 = 1'b1; sl4 = 1'b0; iv4 = 1'b0; id4 = '0; ins4 = '0; isk4 = '0; or4 = 1'b1;
      ref_byte(8'h00, 1'b0, 1'b0, 1'b1, 23'h1DBFBC, mlr, q8);
      ref_byte(8'h00, 1'b0, 1'b0, 1'b1, mlr, mlr, b2);
      tick();
      tick();
      chk("rst_valid", {31'd0, ov1}, 32'd0);
      chk("rst_data", {24'd0, od1}, 32'd0);
      rst_1G = 1'b0; iv1 = 1'b0;
      #1;
      chk("rst_in_ready", {31'd0, ir1}, 32'd1);
      beat1("first_zero", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h6C);
      tick();
      chk("drop_valid", {31'd0, ov1}, 32'd0);

      do_reset();
      beat1("skip_aa", 8'hAA, 1'b1, 1'b0, 1'b1, 1'b0, 8'hAA);
      beat1("after_skip", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h6C);

      do_reset();
      beat1("seedld_beat", 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h6C);
      beat1("after_seedld", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h6C);

      do_reset();
      beat1("pre_idle_sl", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h6C);
      sl1 = 1'b1;
      tick();
      sl1 = 1'b0;
      beat1("idle_seedld", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h6C);

      do_reset();
      beat1("bypass", 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A);
      beat1("after_bypass", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, b2);

      do_reset();
      beat1("noscr", 8'h33, 1'b0, 1'b1, 1'b1, 1'b0, 8'h33);
      beat1("after_noscr", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, b2);

      do_reset();
      or1 = 1'b0;
      beat1("stall_a", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h6C);
      iv1 = 1'b1; id1 = 8'h00;
      for (int c = 0; c < 5; c++) begin
         #1;
         chk("stall_in_ready", {31'd0, ir1}, 32'd0);
         chk("stall_data", {24'd0, od1}, 32'h6C);
         tick();
      end
      chk("stall_valid", {31'd0, ov1}, 32'd1);
      or1 = 1'b1;
      tick();
      iv1 = 1'b0;
      chk("stall_b_valid", {31'd0, ov1}, 32'd1);
      chk("stall_b_data", {24'd0, od1}, {24'd0, b2});
      tick();
      chk("stall_no_dup", {31'd0, ov1}, 32'd0);

      do_reset();
      or1 = 1'b0;
      beat1("prerst_beat", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h6C);
      iv1 = 1'b1;
      rst_1G = 1'b1;
      tick();
      rst_1G = 1'b0; iv1 = 1'b0; or1 = 1'b1;
      chk("midrst_valid", {31'd0, ov1}, 32'd0);
      chk("midrst_data", {24'd0, od1}, 32'd0);
      beat1("midrst_seed", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h6C);

      do_reset();
      mlr  = 23'h19CFC9;
      sent = 0;
      cyc  = 0;
      while ((sent < 64 || exp_q.size() != 0) && cyc < 2000) begin
         d4 = $urandom; sk4 = 4'($urandom); ns4 = 4'($urandom); e = ($urandom_range(0, 7) != 0);
         iv4 = (sent < 64) && ($urandom_range(0, 3) != 0);
         or4 = ($urandom_range(0, 3) != 0);
         id4 = d4; isk4 = sk4; ins4 = ns4; en4 = e;
         #1;
         if (ov4 && or4) begin
            if (exp_q.size() == 0) chk("rand_unexpected", od4, 32'hXXXXXXXX);
            else chk("rand_beat", od4, exp_q.pop_front());
         end
         if (iv4 && ir4) begin
            for (int k = 0; k < 4; k++) begin
               ref_byte(d4[8*k+:8], sk4[k], ns4[k], e, mlr, mlr, q8);
               e4[8*k+:8] = q8;
            end
            exp_q.push_back(e4);
            sent++;
         end
         tick();
         cyc++;
      end
      if (cyc >= 2000) chk("rand_timeout", cyc, 32'd0);
      iv4 = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
